// File: rtl/mem_request_rr_arbiter_if.sv
// Handshake bundle between request sources, the arbiter and the downstream memory request path.
// The slave modport is the arbiter's view; the master modport is the sources' and sink's view.
interface mem_request_rr_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int REQ_W  = 64
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*REQ_W-1:0] in_req;
  logic [NUM_CH-1:0]       in_ready;
  logic                    force_en;
  logic [CH_W-1:0]         force_ch;
  logic                    out_valid;
  logic [REQ_W-1:0]        out_req;
  logic [CH_W-1:0]         out_ch;
  logic                    out_ready;

  modport slave (
    input  in_valid, in_req, force_en, force_ch, out_ready,
    output in_ready, out_valid, out_req, out_ch
  );

  modport master (
    output in_valid, in_req, force_en, force_ch, out_ready,
    input  in_ready, out_valid, out_req, out_ch
  );
endinterface

// File: rtl/mem_request_rr_arbiter.sv
// N-channel memory request arbiter: round-robin or fixed priority with a forced-channel
// override, feeding a single registered output stage with same-cycle pass-through on pop.
module mem_request_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int REQ_W  = 64,
  parameter int MODE   = 0
) (
  input logic clk,
  input logic reset_n,
  mem_request_rr_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0]   rr_ptr;
  logic              out_valid_q;
  logic [REQ_W-1:0]  out_req_q;
  logic [CH_W-1:0]   out_ch_q;

  logic              load_en;
  logic              grant_hit;
  logic [CH_W-1:0]   grant_ch;
  logic [NUM_CH-1:0] below_ptr;
  logic [NUM_CH-1:0] masked_valid;
  logic [NUM_CH-1:0] ready;
  logic              transfer;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] vec);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[CH_W-1:0];
    end
    return idx;
  endfunction

  // Round-robin searches the channels at or above rr_ptr first, falling back to the
  // lowest valid channel overall, which gives the wrap from NUM_CH-1 back to 0.
  always_comb begin
    load_en      = ~out_valid_q | bus.out_ready;
    grant_hit    = 1'b0;
    grant_ch     = '0;
    below_ptr    = '0;
    masked_valid = '0;
    ready        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      below_ptr[i] = (i < int'(rr_ptr));
    end
    masked_valid = bus.in_valid & ~below_ptr;
    if (bus.force_en) begin
      if (int'(bus.force_ch) < NUM_CH) begin
        grant_hit = bus.in_valid[bus.force_ch];
        grant_ch  = bus.force_ch;
      end
    end else if (MODE == 1) begin
      grant_hit = |bus.in_valid;
      grant_ch  = lowest_set(bus.in_valid);
    end else begin
      grant_hit = |bus.in_valid;
      grant_ch  = (|masked_valid) ? lowest_set(masked_valid) : lowest_set(bus.in_valid);
    end
    if (grant_hit && load_en && reset_n) begin
      ready[grant_ch] = 1'b1;
    end
    transfer = |ready;
  end

  // Forced transfers and fixed-priority mode leave the round-robin pointer alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      out_ch_q    <= '0;
      rr_ptr      <= '0;
    end else if (transfer) begin
      out_valid_q <= 1'b1;
      out_req_q   <= bus.in_req[grant_ch*REQ_W +: REQ_W];
      out_ch_q    <= grant_ch;
      if (MODE == 0 && !bus.force_en) begin
        rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_req   = out_req_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_mem_request_rr_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority 4-channel arbiter share stimulus
// and are compared against a channel-search reference model; a 5-channel copy covers force range.
module tb_mem_request_rr_arbiter;
  localparam int N = 4;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [N-1:0]   valid;
  logic [N*W-1:0] req;
  logic           force_en;
  logic [1:0]     force_ch;
  logic           out_ready;

  logic [4:0]     c_valid;
  logic [5*W-1:0] c_req;
  logic           c_force_en;
  logic [2:0]     c_force_ch;
  logic           c_out_ready;

  int checks = 0;
  int errors = 0;

  bit         m_valid [2];
  int         m_ch    [2];
  logic [W-1:0] m_req [2];
  int         m_ptr   [2];
  logic [N-1:0] last_ready_a = '0;
  logic [W-1:0] frozen;
  logic [W-1:0] fresh;

  mem_request_rr_arbiter_if #(.NUM_CH(N), .REQ_W(W)) if_a ();
  mem_request_rr_arbiter_if #(.NUM_CH(N), .REQ_W(W)) if_b ();
  mem_request_rr_arbiter_if #(.NUM_CH(5), .REQ_W(W)) if_c ();

  assign if_a.in_valid  = valid;
  assign if_a.in_req    = req;
  assign if_a.force_en  = force_en;
  assign if_a.force_ch  = force_ch;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = valid;
  assign if_b.in_req    = req;
  assign if_b.force_en  = force_en;
  assign if_b.force_ch  = force_ch;
  assign if_b.out_ready = out_ready;
  assign if_c.in_valid  = c_valid;
  assign if_c.in_req    = c_req;
  assign if_c.force_en  = c_force_en;
  assign if_c.force_ch  = c_force_ch;
  assign if_c.out_ready = c_out_ready;

  mem_request_rr_arbiter #(.NUM_CH(N), .REQ_W(W), .MODE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  mem_request_rr_arbiter #(.NUM_CH(N), .REQ_W(W), .MODE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave));
  mem_request_rr_arbiter #(.NUM_CH(5), .REQ_W(W), .MODE(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c.slave));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: scan channels in service order and take the first valid one.
  function automatic int pick(input int m, input logic [N-1:0] v, input bit fe, input int fc, input int ptr);
    int c;
    if (fe) return v[fc] ? fc : -1;
    for (int k = 0; k < N; k++) begin
      c = (m == 1) ? k : (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0;
      m_ch[m]    = 0;
      m_req[m]   = '0;
      m_ptr[m]   = 0;
    end
  endtask

  task automatic step();
    int g;
    bit load;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] obs_rdy;
    #1;
    for (int m = 0; m < 2; m++) begin
      load = !m_valid[m] || out_ready;
      g = pick(m, valid, force_en, int'(force_ch), m_ptr[m]);
      exp_rdy = (load && g >= 0) ? N'(1 << g) : '0;
      obs_rdy = (m == 0) ? if_a.in_ready : if_b.in_ready;
      check_output($sformatf("in_ready%0d", m), W'(obs_rdy), W'(exp_rdy));
      if (exp_rdy != '0) begin
        m_valid[m] = 1'b1;
        m_req[m]   = req[g*W +: W];
        m_ch[m]    = g;
        if (m == 0 && !force_en) m_ptr[m] = (g + 1) % N;
      end else if (out_ready) begin
        m_valid[m] = 1'b0;
      end
    end
    last_ready_a = if_a.in_ready;
    @(posedge clk);
    #1;
    check_output("out_valid0", W'(if_a.out_valid), W'(m_valid[0]));
    check_output("out_valid1", W'(if_b.out_valid), W'(m_valid[1]));
    if (m_valid[0]) begin
      check_output("out_ch0", W'(if_a.out_ch), W'(m_ch[0]));
      check_output("out_req0", if_a.out_req, m_req[0]);
    end
    if (m_valid[1]) begin
      check_output("out_ch1", W'(if_b.out_ch), W'(m_ch[1]));
      check_output("out_req1", if_b.out_req, m_req[1]);
    end
  endtask

  initial begin
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    valid = '0; force_en = 1'b0; force_ch = '0; out_ready = 1'b0;
    c_valid = '0; c_force_en = 1'b0; c_force_ch = '0; c_out_ready = 1'b0;
    for (int i = 0; i < N; i++) req[i*W +: W] = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) c_req[i*W +: W] = {$urandom, $urandom};
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_out_valid", W'(if_a.out_valid), '0);
    check_output("rst_out_req", if_a.out_req, '0);
    check_output("rst_out_ch", W'(if_a.out_ch), '0);
    check_output("rst_in_ready", W'(if_a.in_ready), '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream with a held output word.
    valid = 4'b1111; out_ready = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_output("midrst_valid_a", W'(if_a.out_valid), '0);
    check_output("midrst_ready_a", W'(if_a.in_ready), '0);
    check_output("midrst_ready_b", W'(if_b.in_ready), '0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Round-robin sequence with everyone valid; fixed priority sticks to ch0.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_output("rr_seq", W'(if_a.out_ch), W'(seq[i]));
      check_output("fp_seq", W'(if_b.out_ch), '0);
    end

    // Backpressure: output frozen, then pop and reload in the same cycle.
    frozen = m_req[0];
    fresh  = {$urandom, $urandom};
    req[2*W +: W] = fresh;
    valid = 4'b0100; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("bp_frozen", if_a.out_req, frozen);
      check_output("bp_ready", W'(last_ready_a), '0);
    end
    out_ready = 1'b1;
    step();
    check_output("bp_reload_rdy", W'(last_ready_a), W'(4'b0100));
    check_output("bp_reload_ch", W'(if_a.out_ch), 2);
    check_output("bp_reload_req", if_a.out_req, fresh);

    // Fixed priority starvation of ch3 while ch1 stays valid.
    valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("fp_starve", W'(if_b.out_ch), 1);
    end
    valid = 4'b1000;
    step();
    check_output("fp_ch3", W'(if_b.out_ch), 3);

    // Forced channel leaves the round-robin pointer where it was (2 after this grant).
    valid = 4'b0010;
    step();
    valid = 4'b1111; force_en = 1'b1; force_ch = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("force_a", W'(if_a.out_ch), 3);
      check_output("force_b", W'(if_b.out_ch), 3);
    end
    force_en = 1'b0;
    step();
    check_output("force_ptr", W'(if_a.out_ch), 2);

    // Sparse round-robin wrap.
    valid = 4'b0001; step();
    valid = 4'b1000; step();
    check_output("sparse_ch3", W'(if_a.out_ch), 3);
    valid = 4'b0001; step();
    check_output("sparse_ch0", W'(if_a.out_ch), 0);
    valid = 4'b1111; step();
    check_output("sparse_next", W'(if_a.out_ch), 1);

    // Randomized traffic; sources hold valid until accepted by the round-robin arbiter.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!(valid[i] && !last_ready_a[i])) begin
          valid[i] = 1'($urandom_range(0, 1));
          req[i*W +: W] = {$urandom, $urandom};
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      force_en  = ($urandom_range(0, 7) == 0);
      force_ch  = 2'($urandom_range(0, 3));
      step();
    end

    // Five-channel instance: out-of-range force grants nothing; non-power-of-two wrap.
    c_out_ready = 1'b1; c_valid = 5'b11111; c_force_en = 1'b1; c_force_ch = 3'd5;
    #1;
    check_output("c_force5_rdy", W'(if_c.in_ready), '0);
    @(posedge clk); #1;
    check_output("c_force5_valid", W'(if_c.out_valid), '0);
    c_force_ch = 3'd7;
    #1;
    check_output("c_force7_rdy", W'(if_c.in_ready), '0);
    @(posedge clk); #1;
    check_output("c_force7_valid", W'(if_c.out_valid), '0);
    c_force_ch = 3'd4;
    #1;
    check_output("c_force4_rdy", W'(if_c.in_ready), W'(5'b10000));
    @(posedge clk); #1;
    check_output("c_force4_ch", W'(if_c.out_ch), 4);
    check_output("c_force4_req", if_c.out_req, c_req[4*W +: W]);
    c_force_en = 1'b0; c_valid = 5'b10000;
    @(posedge clk); #1;
    check_output("c_rr_ch4", W'(if_c.out_ch), 4);
    c_valid = 5'b11111;
    @(posedge clk); #1;
    check_output("c_wrap_ch0", W'(if_c.out_ch), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
